sdram_arbiter_rr: RTL and testbench
===================================

Name: sdram_arbiter_rr

Overview:
- Parametrised N-client arbiter multiplexing one 128-bit SDRAM controller port among independent masters: line buffer, I2S PCM reader, SD-card init loader, and future sprite/note engines.
- Replaces the fixed, frame-sequenced client selection with request-driven arbitration.
- One urgent-priority class plus round-robin among normal clients, a per-grant burst cap, and a per-client enable mask that top-level phase logic drives.

Parameters:
- NUM_CLIENTS, 4, number of requesters (2..8).
- ADDR_W, 22, SDRAM word address width.
- DATA_W, 128, data width; BE_W = DATA_W/8 (derived localparam).
- MAX_BURST, 8, max accepted words per grant before forced re-arbitration (1..255).
- URGENT_MASK, 4'b0010, bit i=1: client i is in the urgent class (PCM by default).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cl_en  in  NUM_CLIENTS  per-client enable; disabled clients are never granted.
- cl_rd  in  NUM_CLIENTS  read request, held until acknowledged.
- cl_wr  in  NUM_CLIENTS  write request, held until acknowledged.
- cl_addr  in  NUM_CLIENTS*ADDR_W  flattened addresses; client i occupies bits [i*ADDR_W +: ADDR_W].
- cl_wrdata  in  NUM_CLIENTS*DATA_W  flattened write data.
- cl_be  in  NUM_CLIENTS*BE_W  flattened byte enables.
- cl_grant  out  NUM_CLIENTS  one-hot current owner; the client's Wait equals ~cl_grant[i].
- cl_ac  out  NUM_CLIENTS  per-client acknowledge pulse.
- cl_rddata  out  DATA_W  ar_rddata broadcast; valid for client i when cl_ac[i]=1.
- ar_addr  out  ADDR_W  to controller.
- ar_be  out  BE_W  to controller.
- ar_read  out  1  to controller.
- ar_write  out  1  to controller.
- ar_wrdata  out  DATA_W  to controller.
- ar_ac  in  1  controller acknowledge, one cycle per word.
- ar_rddata  in  DATA_W  controller read data.
- busy  out  1  high in GRANT state.

Behaviour:
- Reset (asynchronous assert, synchronous release) sets these values:
  - state=IDLE, cl_grant=0, burst_cnt=0, rr_ptr=0.
  - ar_read=0, ar_write=0, cl_ac=0, busy=0.
  - ar_addr, ar_be and ar_wrdata are 0.
- Request vector: req[i] = cl_en[i] & (cl_rd[i] | cl_wr[i]).
- States are IDLE and GRANT.
- IDLE:
  - If any urgent req exists, grant the lowest-index urgent requester.
  - Otherwise grant the first normal requester at or after rr_ptr, searching cyclically.
  - The grant is registered. State moves to GRANT on the next edge and burst_cnt clears.
  - No request: stay in IDLE.
- GRANT (owner g):
  - Master outputs are driven combinationally from client g.
  - ar_read = cl_rd[g] & cl_en[g]; ar_write = cl_wr[g] & cl_en[g] & ~ar_read. Read wins if both are asserted; that case is a protocol error, flagged by assertion.
  - cl_ac[g] = ar_ac; all other cl_ac bits are 0. cl_rddata = ar_rddata always.
- Burst counting:
  - Each ar_ac increments burst_cnt (8-bit, no wrap: the cap is hit first).
- Release: leave GRANT and return to IDLE on the edge where any of these holds:
  - (a) ar_ac=1 and burst_cnt+1 == MAX_BURST.
  - (b) req[g]=0 with no ack in flight, i.e. the client dropped its request or was disabled via cl_en.
  - (c) an urgent req is pending while g is normal and ar_ac=1 (word-boundary preemption).
- On release from a normal owner, rr_ptr = g+1 mod NUM_CLIENTS.
- Latency:
  - One dead cycle (IDLE) between grants, so request to first master assertion is 2 cycles.
  - A back-to-back burst by the same client yields one word per ar_ac with no gaps.
- Outside GRANT, ar_read=ar_write=0 and the address, byte-enable and write-data outputs hold 0.
- Boundaries:
  - cl_en deasserted mid-grant: master request drops the same cycle and release follows on the next edge. A pending controller ack is not expected; the top level must gate enables only between words.
  - Simultaneous release and new requests: arbitration happens in the following IDLE cycle using the updated rr_ptr.
  - A single requester re-wins immediately after a cap release, after the 1-cycle gap.
  - NUM_CLIENTS=1 degenerates to pass-through plus the gap.
  - Reset mid-burst drops ar_read/ar_write immediately, asynchronously.

Decomposition:
- Package sdram_arb_pkg holds:
  - typedef enum logic [0:0] {IDLE, GRANT} arb_state_t;
  - localparams for default ADDR_W/DATA_W;
  - a function onehot2idx.
- Sub-module rr_pick (NUM param; inputs req, ptr; outputs one-hot grant, valid) is reused twice: urgent pick with ptr=0, normal pick with ptr=rr_ptr.

Test Plan:
1. Single client 0 reads 3 words, MAX_BURST=8 -> grant[0] on cycle 2, three cl_ac[0] pulses mirror ar_ac, release after the request drops, busy back to 0.
2. Clients 0, 2, 3 all request continuously, no urgent traffic, MAX_BURST=2 -> grant order 0,2,3,0,..., exactly 2 acks each, 1 idle cycle between grants.
3. Client 0 mid-burst when urgent client 1 raises cl_rd -> client 0 released after its current ack, client 1 granted next; rr_ptr=1 and client 0 resumes afterwards.
4. Write from client 3 with be=16'h00FF, data=128'hA5.. -> ar_write=1, ar_be/ar_wrdata match exactly; cl_rd=cl_wr=1 simultaneously -> read issued, assertion fires.
5. cl_en[2]=0 while client 2 requests -> never granted; enable cleared mid-grant -> ar_read falls same cycle, state returns to IDLE.
6. Reset asserted mid-burst -> ar_read=0 asynchronously, cl_grant=0; after release, first grant goes to client 0 (rr_ptr=0).

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM round-robin arbiter.
// Holds the FSM state type, default bus widths and a one-hot decoder.
// No logic with state lives here.
package sdram_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int ARB_ADDR_W      = 22;
    localparam int ARB_DATA_W      = 128;
    localparam int ARB_MAX_CLIENTS = 8;

    // Index of the set bit in a one-hot vector; 0 when no bit is set.
    function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sdram_arbiter_rr_pick.sv
// Cyclic first-set picker: finds the first request at or after ptr.
// Purely combinational, zero latency.
// No backpressure; the caller decides when to sample the result.
module rr_pick #(
    parameter  int NUM = 4,
    localparam int PW  = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic [NUM-1:0] req,
    input  logic [PW-1:0]  ptr,
    output logic [NUM-1:0] grant,
    output logic           valid
);

    // Walk the requesters starting at ptr, wrapping around, keep the first hit.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int k = 0; k < NUM; k++) begin
            if (!valid && req[(int'(ptr) + k) % NUM]) begin
                grant[(int'(ptr) + k) % NUM] = 1'b1;
                valid                         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter_rr.sv
// N-client arbiter sharing one SDRAM controller port: urgent class first, round-robin otherwise.
// Grant registered one cycle after request; master outputs then follow the owner combinationally.
// Owner is held until burst cap, request drop, or word-boundary preemption by an urgent client.
module sdram_arbiter_rr
    import sdram_arb_pkg::*;
#(
    parameter  int                     NUM_CLIENTS = 4,
    parameter  int                     ADDR_W      = ARB_ADDR_W,
    parameter  int                     DATA_W      = ARB_DATA_W,
    parameter  int                     MAX_BURST   = 8,
    parameter  logic [NUM_CLIENTS-1:0] URGENT_MASK = NUM_CLIENTS'(2),
    parameter  bit                     ASSERT_EN   = 1'b1,
    localparam int                     BE_W        = DATA_W / 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CLIENTS-1:0]        cl_en,
    input  logic [NUM_CLIENTS-1:0]        cl_rd,
    input  logic [NUM_CLIENTS-1:0]        cl_wr,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] cl_wrdata,
    input  logic [NUM_CLIENTS*BE_W-1:0]   cl_be,
    output logic [NUM_CLIENTS-1:0]        cl_grant,
    output logic [NUM_CLIENTS-1:0]        cl_ac,
    output logic [DATA_W-1:0]             cl_rddata,
    output logic [ADDR_W-1:0]             ar_addr,
    output logic [BE_W-1:0]               ar_be,
    output logic                          ar_read,
    output logic                          ar_write,
    output logic [DATA_W-1:0]             ar_wrdata,
    input  logic                          ar_ac,
    input  logic [DATA_W-1:0]             ar_rddata,
    output logic                          busy
);

    localparam int PW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    arb_state_t             state_q;
    logic [NUM_CLIENTS-1:0] grant_q;
    logic [7:0]             burst_q;
    logic [PW-1:0]          rr_ptr_q;
    logic [PW-1:0]          rr_ptr_d;
    logic [PW-1:0]          owner_idx;

    logic [NUM_CLIENTS-1:0] req;
    logic [NUM_CLIENTS-1:0] urg_gnt;
    logic [NUM_CLIENTS-1:0] norm_gnt;
    logic                   urg_vld;
    logic                   norm_vld;

    logic own_req;
    logic own_urgent;
    logic own_rd;
    logic own_wr;
    logic cap_hit;
    logic release_now;
    logic proto_err;

    assign req = cl_en & (cl_rd | cl_wr);

    // Urgent class always searches from index 0 so the lowest urgent index wins.
    rr_pick #(.NUM(NUM_CLIENTS)) u_pick_urg (
        .req   (req & URGENT_MASK),
        .ptr   (PW'(0)),
        .grant (urg_gnt),
        .valid (urg_vld)
    );

    rr_pick #(.NUM(NUM_CLIENTS)) u_pick_norm (
        .req   (req & ~URGENT_MASK),
        .ptr   (rr_ptr_q),
        .grant (norm_gnt),
        .valid (norm_vld)
    );

    // Route the owner's request onto the controller port; everything is zero outside GRANT.
    always_comb begin
        own_req    = 1'b0;
        own_urgent = 1'b0;
        own_rd     = 1'b0;
        own_wr     = 1'b0;
        ar_addr    = '0;
        ar_be      = '0;
        ar_wrdata  = '0;
        cl_ac      = '0;
        if (state_q == GRANT) begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (grant_q[i]) begin
                    own_req    = req[i];
                    own_urgent = URGENT_MASK[i];
                    own_rd     = cl_rd[i] & cl_en[i];
                    own_wr     = cl_wr[i] & cl_en[i];
                    ar_addr    = cl_addr[i*ADDR_W +: ADDR_W];
                    ar_be      = cl_be[i*BE_W +: BE_W];
                    ar_wrdata  = cl_wrdata[i*DATA_W +: DATA_W];
                    cl_ac[i]   = ar_ac;
                end
            end
        end
    end

    assign ar_read   = own_rd;
    assign ar_write  = own_wr & ~own_rd;
    assign cl_rddata = ar_rddata;
    assign cl_grant  = grant_q;
    assign busy      = (state_q == GRANT);
    assign proto_err = (state_q == GRANT) & own_rd & own_wr;

    // Release decision for the current owner and the pointer it leaves behind.
    always_comb begin
        cap_hit     = ar_ac && (({1'b0, burst_q} + 9'd1) == 9'(MAX_BURST));
        release_now = (state_q == GRANT) &&
                      (cap_hit ||
                       (!own_req && !ar_ac) ||
                       (ar_ac && urg_vld && !own_urgent));
        owner_idx   = PW'(onehot2idx(8'(grant_q)));
        rr_ptr_d    = (owner_idx == PW'(NUM_CLIENTS - 1)) ? '0 : owner_idx + PW'(1);
    end

    // Arbitration FSM: IDLE picks an owner, GRANT counts words until release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            burst_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (urg_vld || norm_vld) begin
                        state_q <= GRANT;
                        grant_q <= urg_vld ? urg_gnt : norm_gnt;
                        burst_q <= '0;
                    end
                end
                GRANT: begin
                    if (ar_ac) begin
                        burst_q <= burst_q + 8'd1;
                    end
                    if (release_now) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        if (!own_urgent) begin
                            rr_ptr_q <= rr_ptr_d;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    // An owner must never ask for read and write at once; read is issued regardless.
    generate
        if (ASSERT_EN) begin : g_proto_chk
            always @(posedge clk) begin
                if (reset) begin
                    assert (!proto_err)
                        else $error("sdram_arbiter_rr: owner asserts read and write together");
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sdram_arbiter_rr.sv
module tb_sdram_arbiter_rr;

    localparam int N  = 4;
    localparam int AW = 22;
    localparam int DW = 128;
    localparam int BW = DW / 8;
    localparam int MB = 4;
    localparam logic [N-1:0] UM = 4'b0010;

    logic clk = 1'b0;
    logic reset;

    logic [N-1:0]  en, rd, wr;
    logic [AW-1:0] addr [N];
    logic [DW-1:0] wd   [N];
    logic [BW-1:0] be   [N];

    logic [N*AW-1:0] cl_addr;
    logic [N*DW-1:0] cl_wrdata;
    logic [N*BW-1:0] cl_be;

    logic [N-1:0]  cl_grant, cl_ac;
    logic [DW-1:0] cl_rddata, ar_wrdata, ar_rddata;
    logic [AW-1:0] ar_addr;
    logic [BW-1:0] ar_be;
    logic          ar_read, ar_write, ar_ac, busy;

    int tests = 0;
    int fails = 0;

    // Reference model: owner index (-1 = none), round-robin pointer, words in current grant.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            cl_addr[i*AW +: AW]   = addr[i];
            cl_wrdata[i*DW +: DW] = wd[i];
            cl_be[i*BW +: BW]     = be[i];
        end
    end

    sdram_arbiter_rr #(
        .NUM_CLIENTS (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MAX_BURST   (MB),
        .URGENT_MASK (UM),
        .ASSERT_EN   (1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cl_en     (en),
        .cl_rd     (rd),
        .cl_wr     (wr),
        .cl_addr   (cl_addr),
        .cl_wrdata (cl_wrdata),
        .cl_be     (cl_be),
        .cl_grant  (cl_grant),
        .cl_ac     (cl_ac),
        .cl_rddata (cl_rddata),
        .ar_addr   (ar_addr),
        .ar_be     (ar_be),
        .ar_read   (ar_read),
        .ar_write  (ar_write),
        .ar_wrdata (ar_wrdata),
        .ar_ac     (ar_ac),
        .ar_rddata (ar_rddata),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit reqv(input int i);
        return en[i] && (rd[i] || wr[i]);
    endfunction

    // Expected port values from the model's notion of who owns the controller.
    task automatic check_outputs();
        logic [N-1:0]  eg, ea;
        logic          er, ew;
        logic [AW-1:0] eaddr;
        logic [BW-1:0] ebe;
        logic [DW-1:0] ewd;
        eg = '0; ea = '0; er = 1'b0; ew = 1'b0;
        eaddr = '0; ebe = '0; ewd = '0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            er    = en[m_owner] && rd[m_owner];
            ew    = en[m_owner] && wr[m_owner] && !er;
            eaddr = addr[m_owner];
            ebe   = be[m_owner];
            ewd   = wd[m_owner];
            if (ar_ac) ea[m_owner] = 1'b1;
        end
        chk("grant",  DW'(cl_grant),  DW'(eg));
        chk("busy",   DW'(busy),      DW'(m_owner >= 0));
        chk("read",   DW'(ar_read),   DW'(er));
        chk("write",  DW'(ar_write),  DW'(ew));
        chk("addr",   DW'(ar_addr),   DW'(eaddr));
        chk("be",     DW'(ar_be),     DW'(ebe));
        chk("wrdata", ar_wrdata,      ewd);
        chk("cl_ac",  DW'(cl_ac),     DW'(ea));
        chk("rddata", cl_rddata,      ar_rddata);
    endtask

    // Arbitration rules applied at a clock edge to the inputs present in that cycle.
    task automatic model_edge();
        int  pick;
        bit  upend;
        bit  rel;
        if (m_owner < 0) begin
            pick = -1;
            for (int i = 0; i < N; i++)
                if (pick < 0 && UM[i] && reqv(i)) pick = i;
            for (int k = 0; k < N; k++)
                if (pick < 0 && !UM[(m_ptr + k) % N] && reqv((m_ptr + k) % N)) pick = (m_ptr + k) % N;
            if (pick >= 0) begin
                m_owner = pick;
                m_cnt   = 0;
            end
        end else begin
            upend = 1'b0;
            for (int i = 0; i < N; i++)
                if (UM[i] && reqv(i)) upend = 1'b1;
            rel = (ar_ac && (m_cnt + 1 == MB)) ||
                  (!reqv(m_owner) && !ar_ac) ||
                  (ar_ac && upend && !UM[m_owner]);
            if (ar_ac) m_cnt++;
            if (rel) begin
                if (!UM[m_owner]) m_ptr = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    endtask

    task automatic cycle();
        #2;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Controller acks a word with the given percent chance whenever the owner has a request up.
    task automatic auto_ack(input int pct);
        bit act;
        act = (m_owner >= 0) && en[m_owner] && (rd[m_owner] || wr[m_owner]);
        ar_ac     = act && ($urandom_range(99) < pct);
        ar_rddata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        logic [N-1:0] order [4];
        logic [N-1:0] prev_g;
        int           n_ord;
        int           o_prev;
        logic         a_prev;
        int           k;

        reset = 1'b0;
        en = '0; rd = '0; wr = '0;
        ar_ac = 1'b0; ar_rddata = '0;
        for (int i = 0; i < N; i++) begin
            addr[i] = AW'($urandom); wd[i] = {$urandom, $urandom, $urandom, $urandom};
            be[i] = BW'($urandom);
        end

        // Reset state
        #2;
        chk("rst_grant", DW'(cl_grant), '0);
        chk("rst_busy",  DW'(busy),     '0);
        chk("rst_read",  DW'(ar_read),  '0);
        chk("rst_write", DW'(ar_write), '0);
        chk("rst_addr",  DW'(ar_addr),  '0);
        chk("rst_be",    DW'(ar_be),    '0);
        chk("rst_wd",    ar_wrdata,     '0);
        chk("rst_ac",    DW'(cl_ac),    '0);
        @(posedge clk); #1;
        reset = 1'b1;
        en = '1;

        // Single client 0 reads three words, then drops its request
        rd[0] = 1'b1;
        ar_ac = 1'b0;
        cycle();
        #1;
        chk("t1_grant", DW'(cl_grant), DW'(4'b0001));
        chk("t1_read",  DW'(ar_read),  DW'(1'b1));
        for (int w = 0; w < 3; w++) begin
            ar_ac = 1'b1; ar_rddata = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end
        rd[0] = 1'b0; ar_ac = 1'b0;
        cycle();
        #1;
        chk("t1_busy_after", DW'(busy), '0);
        cycle();

        // Clients 0, 2, 3 all request; pointer now sits at 1 so order is 2, 3, 0, 2
        rd[0] = 1'b1; rd[2] = 1'b1; rd[3] = 1'b1;
        n_ord = 0; prev_g = '0;
        for (int c = 0; c < 40; c++) begin
            auto_ack(100);
            cycle();
            if (cl_grant != '0 && cl_grant != prev_g && n_ord < 4) begin
                order[n_ord] = cl_grant;
                n_ord++;
            end
            prev_g = cl_grant;
        end
        chk("t2_norder", DW'(n_ord),    DW'(4));
        chk("t2_ord0",   DW'(order[0]), DW'(4'b0100));
        chk("t2_ord1",   DW'(order[1]), DW'(4'b1000));
        chk("t2_ord2",   DW'(order[2]), DW'(4'b0001));
        chk("t2_ord3",   DW'(order[3]), DW'(4'b0100));
        rd = '0; ar_ac = 1'b0;
        cycle(); cycle();

        // Urgent client 1 preempts normal client 0 at a word boundary
        rd[0] = 1'b1; ar_ac = 1'b0;
        cycle();
        ar_ac = 1'b1;
        cycle();
        rd[1] = 1'b1; ar_ac = 1'b1;
        cycle();
        ar_ac = 1'b0;
        cycle();
        #1;
        chk("t3_urgent_grant", DW'(cl_grant), DW'(4'b0010));
        rd[1] = 1'b0; ar_ac = 1'b0;
        cycle(); cycle();
        #1;
        chk("t3_resume0", DW'(cl_grant), DW'(4'b0001));
        rd[0] = 1'b0;
        cycle(); cycle();

        // Write from client 3, then read and write together: read wins
        wr[3] = 1'b1; be[3] = 16'h00FF; wd[3] = {16{8'hA5}};
        cycle();
        #1;
        chk("t4_write", DW'(ar_write), DW'(1'b1));
        chk("t4_be",    DW'(ar_be),    DW'(16'h00FF));
        chk("t4_wd",    ar_wrdata,     {16{8'hA5}});
        rd[3] = 1'b1;
        #1;
        chk("t4_rw_read",  DW'(ar_read),  DW'(1'b1));
        chk("t4_rw_write", DW'(ar_write), '0);
        ar_ac = 1'b1;
        cycle();
        rd[3] = 1'b0; wr[3] = 1'b0; ar_ac = 1'b0;
        cycle(); cycle();

        // Disabled client is never granted; disabling the owner drops the request at once
        en[2] = 1'b0; rd[2] = 1'b1;
        for (int c = 0; c < 4; c++) cycle();
        chk("t5_masked", DW'(cl_grant[2]), '0);
        en[2] = 1'b1;
        cycle();
        #1;
        chk("t5_read_on", DW'(ar_read), DW'(1'b1));
        en[2] = 1'b0;
        #1;
        chk("t5_read_off", DW'(ar_read), '0);
        cycle();
        #1;
        chk("t5_released", DW'(busy), '0);
        rd[2] = 1'b0; en[2] = 1'b1;
        cycle();

        // Randomised traffic against the model
        for (int c = 0; c < 600; c++) begin
            o_prev = m_owner;
            a_prev = ar_ac;
            cycle();
            for (int i = 0; i < N; i++) begin
                if (a_prev && o_prev == i && ($urandom_range(1) == 1)) begin
                    rd[i] = 1'b0; wr[i] = 1'b0;
                end else if (!rd[i] && !wr[i] && ($urandom_range(9) < 3)) begin
                    if ($urandom_range(1) == 1) rd[i] = 1'b1; else wr[i] = 1'b1;
                    addr[i] = AW'($urandom);
                    be[i]   = BW'($urandom);
                    wd[i]   = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            if ($urandom_range(19) == 0) begin
                k = $urandom_range(N - 1);
                en[k] = ~en[k];
            end
            auto_ack(70);
        end
        rd = '0; wr = '0; en = '1; ar_ac = 1'b0;
        cycle(); cycle();

        // Asynchronous reset in the middle of a burst
        rd[2] = 1'b1;
        cycle();
        rd[0] = 1'b1;
        ar_ac = 1'b1;
        cycle();
        #2;
        chk("t6_pre_read", DW'(ar_read), DW'(1'b1));
        reset = 1'b0;
        #1;
        chk("t6_async_read",  DW'(ar_read),  '0);
        chk("t6_async_grant", DW'(cl_grant), '0);
        chk("t6_async_busy",  DW'(busy),     '0);
        m_owner = -1; m_ptr = 0; m_cnt = 0;
        ar_ac = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        cycle();
        #1;
        chk("t6_first_after_rst", DW'(cl_grant), DW'(4'b0001));
        rd = '0;
        cycle(); cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
